// File: rtl/sixteen_demux_deserializer_pkg.sv
// Shared constants and state encoding for the 1-to-16 serial demux/deserializer.
package sixteen_demux_deserializer_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/sixteen_demux_deserializer_sel_decoder4to16.sv
// 4-to-16 one-hot decoder producing per-position shadow write enables.
module sel_decoder4to16
  import sixteen_demux_deserializer_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [0:WORD_W-1] o_we
);

  always_comb begin
    o_we = '0;
    for (int i = 0; i < WORD_W; i++) begin
      o_we[i] = i_en && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/sixteen_demux_deserializer.sv
// Serial-to-parallel 1:16 demux: steers each accepted bit into a shadow word, hands off full words via valid/ready.
module sixteen_demux_deserializer
  import sixteen_demux_deserializer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              sync,
  output logic [SEL_W-1:0]  sel,
  output logic [0:WORD_W-1] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [0:WORD_W-1]   r_shadow;
  logic [0:WORD_W-1]   r_dout;
  logic                r_dout_valid;
  logic [0:WORD_W-1]   w_we;
  logic                w_accept;
  logic                w_last;
  logic                w_consume;
  logic                w_out_free;
  logic                w_load_din;
  logic                w_load_hold;

  assign w_accept    = din_valid && din_ready && !sync;
  assign w_last      = w_accept && (r_sel == SEL_W'(WORD_W - 1));
  assign w_consume   = r_dout_valid && dout_ready;
  assign w_out_free  = !r_dout_valid || dout_ready;
  assign w_load_din  = w_last && w_out_free;
  // A sync in HOLD discards the pending word, so it must not also be transferred.
  assign w_load_hold = (r_state == HOLD) && w_consume && !sync;

  sel_decoder4to16 u_dec (
    .i_sel (r_sel),
    .i_en  (w_accept),
    .o_we  (w_we)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FILL: if (w_last && !w_out_free) w_state_nxt = HOLD;
      HOLD: if (w_consume)             w_state_nxt = FILL;
      default:                         w_state_nxt = FILL;
    endcase
    if (sync) w_state_nxt = FILL;
  end

  always_comb begin
    din_ready = (r_state == FILL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel    <= '0;
      r_shadow <= '0;
    end else if (sync) begin
      r_sel    <= '0;
      r_shadow <= '0;
    end else begin
      if (w_accept) r_sel <= r_sel + 1'b1;
      for (int i = 0; i < WORD_W; i++) begin
        if (w_we[i]) r_shadow[i] <= din;
      end
    end
  end

  // The final bit bypasses the shadow so a free output takes the word on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else if (w_load_din) begin
      r_dout       <= {r_shadow[0:WORD_W-2], din};
      r_dout_valid <= 1'b1;
    end else if (w_load_hold) begin
      r_dout       <= r_shadow;
      r_dout_valid <= 1'b1;
    end else if (w_consume) begin
      r_dout_valid <= 1'b0;
    end
  end

  assign sel        = r_sel;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;

endmodule
